// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron layer.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lif_state_e;

  localparam int   LIF_DEFAULT_THRESHOLD = 5;
  localparam logic LIF_W_INIT_BIT        = 1'b1;

  // Clamp v into the signed range of a 'bits'-wide register.
  function automatic logic signed [31:0] lif_sat(input logic signed [31:0] v,
                                                 input int unsigned       bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (v > hi)      lif_sat = hi;
    else if (v < lo) lif_sat = lo;
    else             lif_sat = v;
  endfunction

endpackage

// File: rtl/lif_synapse_sum.sv
// Binary-weight synapse sum: each matching input/weight pair adds +1, each mismatch -1.
module lif_synapse_sum #(
  parameter int SYNAPSES = 32
) (
  input  logic [SYNAPSES-1:0]                 in_i,
  input  logic [SYNAPSES-1:0]                 w_i,
  output logic signed [$clog2(SYNAPSES)+1:0]  sum_o
);

  localparam int SUM_W = $clog2(SYNAPSES) + 2;

  logic [SYNAPSES-1:0] match;
  int                  acc;

  assign match = ~(in_i ^ w_i);

  always_comb begin
    acc = 0;
    for (int i = 0; i < SYNAPSES; i++) begin
      acc = acc + (match[i] ? 1 : -1);
    end
    sum_o = SUM_W'(acc);
  end

endmodule

// File: rtl/lif_layer_tdm.sv
// Layer of leaky integrate-and-fire neurons sharing one datapath, one neuron per cycle.
// Optional refractory period per neuron is enabled with `define LIF_REFRACTORY_EN.
module lif_layer_tdm
  import lif_pkg::*;
#(
  parameter int N_NEURONS      = 4,
  parameter int SYNAPSES       = 32,
  parameter int MEMBRANE_BITS  = 8,
  parameter int THRESHOLD_BITS = 6,
  parameter int REFRACT_STEPS  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             step_valid,
  output logic                             step_ready,
  input  logic [SYNAPSES-1:0]              step_inputs,
  input  logic [THRESHOLD_BITS-1:0]        threshold,
  input  logic [2:0]                       shift,
  input  logic                             cfg_we,
  output logic                             cfg_ready,
  input  logic [$clog2(N_NEURONS)-1:0]     cfg_addr,
  input  logic [SYNAPSES-1:0]              cfg_weights,
  output logic [N_NEURONS-1:0]             spikes,
  output logic                             spikes_valid,
  input  logic [$clog2(N_NEURONS)-1:0]     mon_addr,
  output logic signed [MEMBRANE_BITS-1:0]  mon_membrane
);

  localparam int AW    = $clog2(N_NEURONS);
  localparam int SUM_W = $clog2(SYNAPSES) + 2;
  localparam int VW    = MEMBRANE_BITS + 2;

  lif_state_e                       state_q, state_d;
  logic [AW-1:0]                    idx_q, idx_d;
  logic [SYNAPSES-1:0]              in_q;
  logic [THRESHOLD_BITS-1:0]        thr_q;
  logic [2:0]                       shift_q;
  logic [SYNAPSES-1:0]              w_q   [N_NEURONS];
  logic signed [MEMBRANE_BITS-1:0]  mem_q [N_NEURONS];
  logic [N_NEURONS-1:0]             spk_acc_q;
  logic [N_NEURONS-1:0]             spikes_q;
  logic                             spikes_valid_q;

  logic signed [SUM_W-1:0]          syn_sum;
  logic signed [SUM_W-1:0]          sum_eff;
  logic signed [MEMBRANE_BITS-1:0]  m_cur;
  logic signed [MEMBRANE_BITS-1:0]  leak;
  logic signed [VW-1:0]             v_full;
  logic signed [MEMBRANE_BITS-1:0]  v_sat;
  logic signed [VW-1:0]             thr_x;
  logic                             spike;
  logic signed [MEMBRANE_BITS-1:0]  m_new;
  logic                             refr_busy;

  assign step_ready   = (state_q == IDLE);
  assign cfg_ready    = (state_q == IDLE);
  assign spikes       = spikes_q;
  assign spikes_valid = spikes_valid_q;
  assign mon_membrane = (int'(mon_addr) < N_NEURONS) ? mem_q[mon_addr] : '0;

  lif_synapse_sum #(.SYNAPSES(SYNAPSES)) u_sum (
    .in_i  (in_q),
    .w_i   (w_q[idx_q]),
    .sum_o (syn_sum)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRACT_STEPS + 1);
  logic [RW-1:0] refr_q [N_NEURONS];

  assign refr_busy = (refr_q[idx_q] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
    end else if (state_q == SWEEP) begin
      if (refr_busy)  refr_q[idx_q] <= refr_q[idx_q] - 1'b1;
      else if (spike) refr_q[idx_q] <= RW'(REFRACT_STEPS);
    end
  end
`else
  assign refr_busy = 1'b0;
`endif

  // Membrane update for the neuron in the current sweep slot.
  always_comb begin
    m_cur   = mem_q[idx_q];
    sum_eff = refr_busy ? '0 : syn_sum;
    if (shift_q == 3'd0) leak = '0;
    else                 leak = m_cur >>> shift_q;
    v_full = VW'(m_cur) - VW'(leak) + VW'(sum_eff);
    v_sat  = MEMBRANE_BITS'(lif_sat(32'(v_full), MEMBRANE_BITS));
    thr_x  = $signed(VW'({1'b0, thr_q}));
    spike  = !refr_busy && (VW'(v_sat) >= thr_x);
    m_new  = spike ? MEMBRANE_BITS'(VW'(v_sat) - thr_x) : v_sat;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (step_valid) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == AW'(N_NEURONS - 1)) state_d = DONE;
        else                             idx_d   = idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      in_q           <= '0;
      thr_q          <= THRESHOLD_BITS'(LIF_DEFAULT_THRESHOLD);
      shift_q        <= '0;
      spk_acc_q      <= '0;
      spikes_q       <= '0;
      spikes_valid_q <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= '0;
        w_q[i]   <= {SYNAPSES{LIF_W_INIT_BIT}};
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      spikes_valid_q <= (state_q == DONE);
      if (state_q == DONE) spikes_q <= spk_acc_q;
      if (state_q == IDLE && step_valid) begin
        in_q    <= step_inputs;
        thr_q   <= threshold;
        shift_q <= shift;
      end
      // A write in the accept cycle lands before the first sweep slot reads the row.
      if (state_q == IDLE && cfg_we && int'(cfg_addr) < N_NEURONS)
        w_q[cfg_addr] <= cfg_weights;
      if (state_q == SWEEP) begin
        mem_q[idx_q]     <= m_new;
        spk_acc_q[idx_q] <= spike;
      end
    end
  end

endmodule

// File: tb/tb_lif_layer_tdm.sv
// Self-checking bench for lif_layer_tdm against an arithmetic reference model of the layer.
module tb_lif_layer_tdm;

  localparam int N   = 4;
  localparam int SYN = 32;
  localparam int MB  = 8;
  localparam int TB_ = 6;
  localparam int RS  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              step_valid;
  logic              step_ready;
  logic [SYN-1:0]    step_inputs;
  logic [TB_-1:0]    threshold;
  logic [2:0]        shift;
  logic              cfg_we;
  logic              cfg_ready;
  logic [1:0]        cfg_addr;
  logic [SYN-1:0]    cfg_weights;
  logic [N-1:0]      spikes;
  logic              spikes_valid;
  logic [1:0]        mon_addr;
  logic signed [MB-1:0] mon_membrane;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int             m_mem  [N];
  logic [SYN-1:0] m_w    [N];
  int             m_refr [N];
  int             m_spk;

  lif_layer_tdm #(
    .N_NEURONS(N), .SYNAPSES(SYN), .MEMBRANE_BITS(MB),
    .THRESHOLD_BITS(TB_), .REFRACT_STEPS(RS)
  ) dut (
    .clk(clk), .reset(reset),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_inputs(step_inputs), .threshold(threshold), .shift(shift),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_weights(cfg_weights),
    .spikes(spikes), .spikes_valid(spikes_valid),
    .mon_addr(mon_addr), .mon_membrane(mon_membrane)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      m_mem[n] = 0; m_w[n] = '1; m_refr[n] = 0;
    end
    m_spk = 0;
  endtask

  task automatic model_step(input logic [SYN-1:0] in, input int thr, input int sh);
    int sum, leak, v;
    bit busy, fire;
    m_spk = 0;
    for (int n = 0; n < N; n++) begin
`ifdef LIF_REFRACTORY_EN
      busy = (m_refr[n] != 0);
`else
      busy = 1'b0;
`endif
      sum  = busy ? 0 : 2 * $countones(~(in ^ m_w[n])) - SYN;
      leak = (sh == 0) ? 0 : (m_mem[n] >>> sh);
      v    = m_mem[n] - leak + sum;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      fire = !busy && (v >= thr);
      m_mem[n] = fire ? v - thr : v;
      if (busy)      m_refr[n] = m_refr[n] - 1;
      else if (fire) m_refr[n] = RS;
      if (fire) m_spk = m_spk | (1 << n);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic check_mems(input string tag);
    for (int n = 0; n < N; n++) begin
      mon_addr = 2'(n);
      #1 chk(tag, int'(mon_membrane), m_mem[n]);
    end
  endtask

  task automatic cfg_write(input int addr, input logic [SYN-1:0] row);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_weights = row;
    @(posedge clk); #1 cfg_we = 1'b0;
    if (addr < N) m_w[addr] = row;
  endtask

  task automatic do_step(input logic [SYN-1:0] in, input int thr, input int sh,
                         input bit wr_accept, input bit wr_sweep,
                         input int wa, input logic [SYN-1:0] wrow);
    int  cyc;
    bit  seen;
    cyc = 0;
    while (!step_ready && cyc < 20) begin @(posedge clk); #1 cyc++; end
    chk("step_ready_idle", int'(step_ready), 1);
    step_inputs = in; threshold = TB_'(thr); shift = 3'(sh); step_valid = 1'b1;
    if (wr_accept) begin
      cfg_we = 1'b1; cfg_addr = 2'(wa); cfg_weights = wrow; m_w[wa] = wrow;
    end
    @(posedge clk); #1 step_valid = 1'b0; cfg_we = 1'b0;
    model_step(in, thr, sh);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      cfg_we = (wr_sweep && cyc == 1);
      cfg_addr = 2'(wa); cfg_weights = wrow;
      @(posedge clk); #1 cyc++;
      if (cyc == 2) chk("step_ready_busy", int'(step_ready), 0);
      seen = spikes_valid;
    end
    cfg_we = 1'b0;
    chk("latency", cyc, N + 1);
    chk("spikes", int'(spikes), m_spk);
    @(posedge clk); #1 chk("valid_pulse", int'(spikes_valid), 0);
  endtask

  initial begin
    int exp2 [5];
    int e6;
    logic [SYN-1:0] rin, rrow;
    reset = 1'b1; step_valid = 1'b0; step_inputs = '0; threshold = '0; shift = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_weights = '0; mon_addr = '0;

    // reset state
    do_reset();
    chk("rst_spikes", int'(spikes), 0);
    chk("rst_valid", int'(spikes_valid), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    check_mems("rst_mem");

    // all-ones inputs, default weights
    do_step('1, 5, 0, 0, 0, 0, '0);
    chk("t1_spikes", int'(spikes), 4'b1111);
    for (int n = 0; n < N; n++) begin
      mon_addr = 2'(n); #1 chk("t1_mem", int'(mon_membrane), 27);
    end

    // negative saturation
    do_reset();
    exp2 = '{-32, -64, -96, -128, -128};
    for (int s = 0; s < 5; s++) begin
      do_step('0, 5, 0, 0, 0, 0, '0);
      chk("t2_spikes", int'(spikes), 0);
      mon_addr = 2'(s % N); #1 chk("t2_mem", int'(mon_membrane), exp2[s]);
    end

    // inhibitory row on neuron 2
    do_reset();
    cfg_write(2, '0);
    do_step('1, 40, 0, 0, 0, 0, '0);
    chk("t3_spk1", int'(spikes), 0);
    mon_addr = 2'd2; #1 chk("t3_m2", int'(mon_membrane), -32);
    mon_addr = 2'd0; #1 chk("t3_m0", int'(mon_membrane), 32);
    do_step('1, 40, 0, 0, 0, 0, '0);
    chk("t3_spk2", int'(spikes), 4'b1011);
    mon_addr = 2'd1; #1 chk("t3_m1", int'(mon_membrane), 24);
    check_mems("t3_mem");

    // leak with zero synaptic sum
    do_reset();
    do_step('1, 63, 0, 0, 0, 0, '0);
    mon_addr = 2'd3; #1 chk("t4_m_a", int'(mon_membrane), 32);
    do_step(32'h0000_FFFF, 63, 1, 0, 0, 0, '0);
    mon_addr = 2'd3; #1 chk("t4_m_b", int'(mon_membrane), 16);
    do_step(32'h5555_5555, 63, 1, 0, 0, 0, '0);
    mon_addr = 2'd3; #1 chk("t4_m_c", int'(mon_membrane), 8);

    // write dropped during sweep, write with accept honoured
    do_reset();
    do_step('1, 40, 0, 0, 1, 0, '0);
    do_step('1, 40, 0, 0, 0, 0, '0);
    check_mems("t5_drop");
    do_step('1, 40, 0, 1, 0, 1, '0);
    check_mems("t5_accept");
    mon_addr = 2'd1; #1 chk("t5_m1", int'(mon_membrane), -8);

    // refractory behaviour
    do_reset();
    for (int s = 1; s <= 7; s++) begin
      do_step('1, 5, 0, 0, 0, 0, '0);
`ifdef LIF_REFRACTORY_EN
      e6 = (s == 1 || s == 4 || s == 7) ? 15 : 0;
`else
      e6 = 15;
`endif
      chk("t6_spikes", int'(spikes), e6);
    end

    // reset in the middle of a sweep
    step_valid = 1'b1; step_inputs = '1; threshold = 6'd1;
    @(posedge clk); #1 step_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    e6 = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1 if (spikes_valid) e6++;
    end
    chk("abort_no_valid", e6, 0);
    check_mems("abort_mem");

    // randomized steps and weight writes
    do_reset();
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        rrow = $urandom;
        cfg_write(int'($urandom_range(0, N - 1)), rrow);
      end
      rin  = $urandom;
      rrow = $urandom;
      do_step(rin, int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, N - 1)), rrow);
      check_mems("rnd_mem");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
